// File: rtl/round_robin_checker.sv
// Round-robin arbiter checker: watches request/grant vectors, counts grants
// per requester and arbitration cycles, and raises sticky error flags for
// non-one-hot grants, spurious grants, order violations and starvation.
// Optional feature macro: ROUND_ROBIN_ORDER_CHECK_EN enables the last-grant
// pointer and the ORDER check; without it error bit2 is tied to 0.
module round_robin_checker #(
    parameter int unsigned REQUEST_WIDTH = 8,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_clear,
    input  logic [REQUEST_WIDTH-1:0]                  i_request,
    input  logic [REQUEST_WIDTH-1:0]                  i_grant,
    output logic [REQUEST_WIDTH-1:0][COUNT_WIDTH-1:0] o_grant_count,
    output logic [COUNT_WIDTH-1:0]                    o_arb_count,
    output logic [3:0]                                o_error_code,
    output logic                                      o_error
);

    localparam int unsigned IDX_WIDTH  = $clog2(REQUEST_WIDTH);
    localparam int unsigned WAIT_WIDTH = IDX_WIDTH + 1;
    localparam logic [WAIT_WIDTH-1:0]  WAIT_LIMIT = WAIT_WIDTH'(REQUEST_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    logic                                     arb_cycle;
    logic                                     grant_onehot;
    logic [IDX_WIDTH-1:0]                     grant_idx;
    logic                                     err_onehot;
    logic                                     err_spurious;
    logic                                     err_order;
    logic                                     err_starve;
    logic [3:0]                               error_code_d;
    logic [REQUEST_WIDTH-1:0][WAIT_WIDTH-1:0] wait_q;
    logic [REQUEST_WIDTH-1:0][WAIT_WIDTH-1:0] wait_d;

    // Classify the cycle and decode the granted index.
    always_comb begin
        arb_cycle    = (i_request != '0);
        grant_onehot = $onehot(i_grant);
        grant_idx    = '0;
        for (int unsigned i = 0; i < REQUEST_WIDTH; i++) begin
            if (i_grant[i]) begin
                grant_idx = IDX_WIDTH'(i);
            end
        end
        err_onehot   = arb_cycle && !grant_onehot;
        err_spurious = ((i_grant & ~i_request) != '0);
    end

    // Per-requester wait counters: count cycles spent requesting but not granted.
    always_comb begin
        err_starve = 1'b0;
        for (int unsigned i = 0; i < REQUEST_WIDTH; i++) begin
            if (arb_cycle && i_request[i] && !i_grant[i]) begin
                wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + WAIT_WIDTH'(1);
            end else begin
                wait_d[i] = '0;
            end
            if (wait_d[i] >= WAIT_LIMIT) begin
                err_starve = 1'b1;
            end
        end
    end

`ifdef ROUND_ROBIN_ORDER_CHECK_EN
    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] expect_idx;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 expect_found;

    // Next expected grant: first requester found upward from pointer+1, wrapping.
    always_comb begin
        expect_idx   = '0;
        cand_idx     = '0;
        expect_found = 1'b0;
        for (int unsigned k = 1; k <= REQUEST_WIDTH; k++) begin
            cand_idx = IDX_WIDTH'((32'(ptr_q) + k) % REQUEST_WIDTH);
            if (!expect_found && i_request[cand_idx]) begin
                expect_idx   = cand_idx;
                expect_found = 1'b1;
            end
        end
        err_order = arb_cycle && grant_onehot && (grant_idx != expect_idx);
    end

    // Last-grant pointer follows every valid one-hot grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= IDX_WIDTH'(REQUEST_WIDTH - 1);
        end else if (i_clear) begin
            ptr_q <= IDX_WIDTH'(REQUEST_WIDTH - 1);
        end else if (arb_cycle && grant_onehot) begin
            ptr_q <= grant_idx;
        end
    end
`else
    // Order checking compiled out.
    always_comb begin
        err_order = 1'b0;
    end
`endif

    // Sticky error accumulation.
    always_comb begin
        error_code_d = o_error_code | {err_starve, err_order, err_spurious, err_onehot};
    end

    // Registered counters, wait state and error outputs; clear beats update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_grant_count <= '0;
            o_arb_count   <= '0;
            o_error_code  <= '0;
            o_error       <= 1'b0;
            wait_q        <= '0;
        end else if (i_clear) begin
            o_grant_count <= '0;
            o_arb_count   <= '0;
            o_error_code  <= '0;
            o_error       <= 1'b0;
            wait_q        <= '0;
        end else begin
            if (arb_cycle) begin
                if (o_arb_count != COUNT_MAX) begin
                    o_arb_count <= o_arb_count + COUNT_WIDTH'(1);
                end
                if (grant_onehot && (o_grant_count[grant_idx] != COUNT_MAX)) begin
                    o_grant_count[grant_idx] <= o_grant_count[grant_idx] + COUNT_WIDTH'(1);
                end
            end
            o_error_code <= error_code_d;
            o_error      <= |error_code_d;
            wait_q       <= wait_d;
        end
    end

endmodule

// File: tb/tb_round_robin_checker.sv
// Self-checking bench for round_robin_checker (8 requesters, 5-bit counters so
// saturation is reachable). Expected outputs come from a behavioural model and
// are queued when stimulus is applied, then popped after the sampling edge.
module tb_round_robin_checker;

    localparam int RW   = 8;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam int WMAX = 15;

    logic                       clk;
    logic                       rst_n;
    logic                       clear;
    logic [RW-1:0]              request;
    logic [RW-1:0]              grant;
    logic [RW-1:0][CW-1:0]      grant_count;
    logic [CW-1:0]              arb_count;
    logic [3:0]                 error_code;
    logic                       error;

    round_robin_checker #(
        .REQUEST_WIDTH(RW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_request    (request),
        .i_grant      (grant),
        .o_grant_count(grant_count),
        .o_arb_count  (arb_count),
        .o_error_code (error_code),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0][CW-1:0] gc;
        logic [CW-1:0]         arb;
        logic [3:0]            ec;
        logic                  e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model state
    int m_gc[RW];
    int m_arb;
    logic [3:0] m_ec;
    int m_ptr;
    int m_wait[RW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RW; i++) begin
            m_gc[i]   = 0;
            m_wait[i] = 0;
        end
        m_arb = 0;
        m_ec  = 4'b0;
        m_ptr = RW - 1;
    endtask

    task automatic model_step(input logic [RW-1:0] req, input logic [RW-1:0] gnt,
                              input logic clr);
        logic [3:0] nw;
        int idx;
        int e;
        int j;
        nw  = 4'b0;
        idx = 0;
        e   = -1;
        if (clr) begin
            model_reset();
            return;
        end
        for (int i = 0; i < RW; i++) if (gnt[i]) idx = i;
        if ((gnt & ~req) != 0) nw[1] = 1'b1;
        if (req != 0) begin
            if (m_arb < CMAX) m_arb++;
            if ($countones(gnt) == 1) begin
                if (m_gc[idx] < CMAX) m_gc[idx]++;
`ifdef ROUND_ROBIN_ORDER_CHECK_EN
                for (int k = 1; k <= RW; k++) begin
                    j = (m_ptr + k) % RW;
                    if (e < 0 && req[j]) e = j;
                end
                if (e != idx) nw[2] = 1'b1;
                m_ptr = idx;
`endif
            end else begin
                nw[0] = 1'b1;
            end
        end
        for (int i = 0; i < RW; i++) begin
            if (req != 0 && req[i] && !gnt[i]) begin
                if (m_wait[i] < WMAX) m_wait[i]++;
            end else begin
                m_wait[i] = 0;
            end
            if (m_wait[i] >= RW) nw[3] = 1'b1;
        end
        m_ec = m_ec | nw;
    endtask

    task automatic push_expected();
        exp_t x;
        for (int i = 0; i < RW; i++) x.gc[i] = CW'(m_gc[i]);
        x.arb = CW'(m_arb);
        x.ec  = m_ec;
        x.e   = |m_ec;
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        x = sb.pop_front();
        chk({tag, ".gc"}, 64'(grant_count), 64'(x.gc));
        chk({tag, ".arb"}, 64'(arb_count), 64'(x.arb));
        chk({tag, ".ec"}, 64'(error_code), 64'(x.ec));
        chk({tag, ".err"}, 64'(error), 64'(x.e));
    endtask

    // Drive one cycle, update model, then compare just after the edge.
    task automatic step(input string tag, input logic [RW-1:0] req, input logic [RW-1:0] gnt,
                        input logic clr);
        request = req;
        grant   = gnt;
        clear   = clr;
        model_step(req, gnt, clr);
        push_expected();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        logic [RW-1:0] r;
        logic [RW-1:0] g;
        rst_n   = 1'b0;
        clear   = 1'b0;
        request = '0;
        grant   = '0;
        model_reset();
        #3;
        chk("reset_arb", 64'(arb_count), 64'd0);
        chk("reset_ec", 64'(error_code), 64'd0);
        chk("reset_gc", 64'(grant_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 8'h00, 8'h00, 1'b0);

        // Fair rotation across all requesters
        for (int i = 0; i < RW; i++) step("rotate", 8'hFF, 8'(1 << i), 1'b0);
        for (int i = 0; i < RW; i++) chk("rotate_gc", 64'(grant_count[i]), 64'd1);
        chk("rotate_arb", 64'(arb_count), 64'd8);
        chk("rotate_err", 64'(error), 64'd0);

        // Clear together with a grant: grant not counted
        step("clear", 8'hFF, 8'h10, 1'b1);
        chk("clear_arb", 64'(arb_count), 64'd0);
        chk("clear_gc", 64'(grant_count), 64'd0);

        // Two-hot grant, sticky after valid grants
        step("twohot", 8'hFF, 8'h03, 1'b0);
        chk("twohot_ec", 64'(error_code), 64'b0001);
        step("twohot_after", 8'hFF, 8'h01, 1'b0);
        step("twohot_after", 8'hFF, 8'h02, 1'b0);
        chk("twohot_sticky", 64'(error_code), 64'b0001);
        step("clear", 8'h00, 8'h00, 1'b1);

        // Spurious grant in an idle cycle
        step("spurious", 8'h00, 8'h04, 1'b0);
        chk("spurious_ec", 64'(error_code), 64'b0010);
        chk("spurious_arb", 64'(arb_count), 64'd0);
        step("clear", 8'h00, 8'h00, 1'b1);

        // Out-of-order grant
        step("order_pre", 8'h01, 8'h01, 1'b0);
        step("order", 8'h0A, 8'h08, 1'b0);
`ifdef ROUND_ROBIN_ORDER_CHECK_EN
        chk("order_ec", 64'(error_code), 64'b0100);
`else
        chk("order_err", 64'(error), 64'd0);
`endif
        step("clear", 8'h00, 8'h00, 1'b1);

        // Starvation of requester 7
        for (int i = 1; i <= 7; i++) step("starve", 8'h81, 8'h01, 1'b0);
        chk("starve_pre", 64'(error_code[3]), 64'd0);
        step("starve8", 8'h81, 8'h01, 1'b0);
        chk("starve_set", 64'(error_code[3]), 64'd1);
        for (int i = 0; i < 10; i++) step("starve_sat", 8'h81, 8'h01, 1'b0);
        step("clear", 8'h00, 8'h00, 1'b1);

        // Counter saturation
        for (int i = 0; i < CMAX + 6; i++) step("sat", 8'h01, 8'h01, 1'b0);
        chk("sat_arb", 64'(arb_count), 64'(CMAX));
        chk("sat_gc0", 64'(grant_count[0]), 64'(CMAX));
        step("clear", 8'h00, 8'h00, 1'b1);

        // Mixed pseudo-random traffic, mostly legal one-hot grants
        for (int n = 0; n < 40; n++) begin
            r = 8'($urandom_range(0, 255));
            g = '0;
            if (r != 0) begin
                for (int t = 0; t < 8; t++) begin
                    g = 8'(1 << $urandom_range(0, RW - 1));
                    if ((g & r) != 0) break;
                end
            end
            if ($urandom_range(0, 7) == 0) g = 8'($urandom_range(0, 255));
            step("mixed", r, g, 1'b0);
        end

        // Reset mid-burst: outputs go to zero without a clock edge
        step("clear", 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step("burst", 8'hFF, 8'(1 << i), 1'b0);
        step("burst_bad", 8'hFF, 8'h06, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_arb", 64'(arb_count), 64'd0);
        chk("rst_gc", 64'(grant_count), 64'd0);
        chk("rst_ec", 64'(error_code), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("resume", 8'hFF, 8'h01, 1'b0);
        chk("resume_arb", 64'(arb_count), 64'd1);
        step("resume2", 8'hFF, 8'h02, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
